// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring DIV/DIVU sequencer for HI/LO write-back,
// with signed fix-up, divide-by-zero completion and annul.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               annul_i,
  output logic               stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, ZERO, DONE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d, rem_q, rem_d, quo_q, quo_d;
  logic nq_q, nq_d, nr_q, nr_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] abs_a, abs_b, step_rem, step_quo, fin_rem, fin_quo;
  logic [WIDTH:0] trial, diff;
  logic borrow;
  assign abs_a = (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign abs_b = (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;
  // Partial remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
  assign trial    = {rem_q, quo_q[WIDTH-1]};
  assign diff     = trial - {1'b0, div_q};
  assign borrow   = diff[WIDTH];
  assign step_rem = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], ~borrow};
  assign fin_rem  = nr_q ? -step_rem : step_rem;
  assign fin_quo  = nq_q ? -step_quo : step_quo;
  assign result_o = res_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    res_d   = res_q;
    stall_o = 1'b0;
    ready_o = 1'b0;
    if (annul_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          stall_o = resetn;
          if (opb_i == '0) begin
            state_d = ZERO;
            res_d   = {opa_i, {WIDTH{1'b1}}};
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            div_d   = abs_b;
            rem_d   = '0;
            quo_d   = abs_a;
            nq_d    = signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
            nr_d    = signed_i & opa_i[WIDTH-1];
          end
        end
        CALC: begin
          stall_o = 1'b1;
          rem_d   = step_rem;
          quo_d   = step_quo;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            res_d   = {fin_rem, fin_quo};
          end
        end
        ZERO, DONE: begin
          ready_o = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: random and directed stimulus against a cycle-level behavioural
// model of the divide sequencer.
module tb_div_sequencer;
  logic        clk = 1'b0;
  logic        resetn, start_i, signed_i, annul_i;
  logic [31:0] opa_i, opb_i;
  logic        stall_o, ready_o;
  logic [63:0] result_o;
  int n_chk = 0;
  int n_err = 0;
  int ph = 0;
  bit zop = 1'b0;
  logic [63:0] pend = '0;
  logic [63:0] exp_res = '0;

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .signed_i(signed_i),
    .opa_i(opa_i), .opb_i(opb_i), .annul_i(annul_i),
    .stall_o(stall_o), .ready_o(ready_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Truncating division in 64-bit arithmetic; quotient and remainder are the low words.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x, y, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    x = s ? longint'($signed(a)) : longint'({32'd0, a});
    y = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // ph counts cycles since the accepted start: 0 idle, completion at 1 (zero) or 33.
  always @(posedge clk) begin
    if (!resetn) begin
      ph <= 0;
      exp_res <= '0;
    end else if (annul_i) begin
      ph <= 0;
    end else if (ph == 0) begin
      if (start_i) begin
        ph   <= 1;
        zop  <= (opb_i == 32'd0);
        pend <= ref_div(opa_i, opb_i, signed_i);
        if (opb_i == 32'd0) exp_res <= ref_div(opa_i, opb_i, signed_i);
      end
    end else if (ph == (zop ? 1 : 33)) begin
      ph <= 0;
    end else begin
      ph <= ph + 1;
      if (ph == 32) exp_res <= pend;
    end
  end

  always @(negedge clk) begin
    logic es, er;
    if (!resetn || annul_i) begin
      es = 1'b0;
      er = 1'b0;
    end else if (ph == 0) begin
      es = start_i;
      er = 1'b0;
    end else if (zop) begin
      es = 1'b0;
      er = (ph == 1);
    end else begin
      es = (ph <= 32);
      er = (ph == 33);
    end
    chk("stall", {63'd0, stall_o}, {63'd0, es});
    chk("ready", {63'd0, ready_o}, {63'd0, er});
    chk("result", result_o, resetn ? exp_res : 64'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input bit hold,
                       output int rc, output logic [63:0] r);
    rc = -1;
    r = '0;
    start_i = 1'b1; signed_i = s; opa_i = a; opb_i = b;
    for (int c = 0; c < 40 && rc < 0; c++) begin
      @(negedge clk);
      if (ready_o) begin
        rc = c;
        r = result_o;
      end
      tick();
      if (!hold) start_i = 1'b0;
    end
    start_i = 1'b0;
  endtask

  initial begin
    int rc, rc2, nr, hl, ab, sel;
    logic [63:0] r;
    logic [31:0] a, b;
    resetn = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opa_i = '0; opb_i = '0;
    repeat (3) tick();
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    resetn = 1'b1;
    tick();

    do_op(32'd7, 32'd2, 1'b0, 1'b0, rc, r);
    chk("divu_7_2_cycle", 64'(rc), 64'd33);
    chk("divu_7_2", r, {32'h1, 32'h3});
    do_op(32'hFFFF_FFF9, 32'h2, 1'b1, 1'b0, rc, r);
    chk("div_m7_2", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(32'h7, 32'hFFFF_FFFE, 1'b1, 1'b0, rc, r);
    chk("div_7_m2", r, {32'h1, 32'hFFFF_FFFD});
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, rc, r);
    chk("div_ovf", r, {32'h0, 32'h8000_0000});
    do_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, rc, r);
    chk("divu_max_1", r, {32'h0, 32'hFFFF_FFFF});
    do_op(32'h1234, 32'h0, 1'b0, 1'b0, rc, r);
    chk("dz_cycle", 64'(rc), 64'd1);
    chk("dz_result", r, {32'h1234, 32'hFFFF_FFFF});

    start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd1000; opb_i = 32'd3; nr = 0;
    for (int c = 0; c < 12; c++) begin
      annul_i = (c == 10);
      @(negedge clk);
      if (ready_o) nr++;
      if (c == 10) chk("abort_stall", {63'd0, stall_o}, 64'd0);
      if (c == 11) chk("abort_hold", result_o, {32'h1234, 32'hFFFF_FFFF});
      tick();
      start_i = 1'b0;
    end
    annul_i = 1'b0;
    chk("abort_noready", 64'(nr), 64'd0);
    do_op(32'd100, 32'd7, 1'b0, 1'b0, rc, r);
    chk("after_abort_cycle", 64'(12 + rc), 64'd45);
    chk("after_abort", r, {32'd2, 32'd14});

    start_i = 1'b1; signed_i = 1'b1; opa_i = 32'hFFFF_FF9C; opb_i = 32'd3; nr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready_o) nr++;
      tick();
      start_i = 1'b0;
    end
    resetn = 1'b0;
    #1;
    chk("mid_rst_stall", {63'd0, stall_o}, 64'd0);
    chk("mid_rst_ready", {63'd0, ready_o}, 64'd0);
    chk("mid_rst_result", result_o, 64'd0);
    chk("mid_rst_noready", 64'(nr), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();
    do_op(32'd50, 32'd5, 1'b0, 1'b1, rc, r);
    chk("b2b_first_cycle", 64'(rc), 64'd33);
    chk("b2b_first", r, {32'd0, 32'd10});
    do_op(32'hFFFF_FFFF, 32'd16, 1'b0, 1'b1, rc2, r);
    chk("b2b_second_cycle", 64'(34 + rc2), 64'd67);
    chk("b2b_second", r, {32'hF, 32'h0FFF_FFFF});

    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 5));
      b = sel == 0 ? 32'd0 : sel == 1 ? 32'hFFFF_FFFF : sel == 2 ? $urandom_range(1, 20) : $urandom;
      a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      signed_i = 1'($urandom_range(0, 1));
      opa_i = a; opb_i = b;
      hl = int'($urandom_range(1, 36));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 35)) : -1;
      for (int c = 0; c < 36; c++) begin
        annul_i = (c == ab);
        start_i = (c < hl);
        tick();
      end
    end
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (40) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
